// File: rtl/rx_demux_if.sv
// AXI-Stream style 32-bit word channel shared by the receive FIFO and the three sinks of rx_demux.
// master drives valid/data/last and samples ready; slave is the mirror image.
interface rx_demux_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rx_demux.sv
// Receive-side demultiplexer: steers whole packets from the bridge RX FIFO to slot 1, slot 2 or pass-through.
// Optional feature RXDMX_DROP_EN: packets whose header ID equals DROP_ID are consumed and discarded.
module rx_demux #(
    parameter logic [7:0]  SLT1_ID   = 8'h01,
    parameter logic [7:0]  SLT2_ID   = 8'h02,
    parameter logic [7:0]  DROP_ID   = 8'hFF,
    parameter int unsigned MAX_WORDS = 380
) (
    input  logic        clk,
    input  logic        rst,
    rx_demux_if.slave   rxif_fifo,
    rx_demux_if.master  slt1_fifo,
    rx_demux_if.master  slt2_fifo,
    rx_demux_if.master  passThru_fifo,
    output logic        oversize,
    output logic [1:0]  dbg_state
);

    // Handshake: a word moves on a rising clk edge where tvalid && tready are both high;
    // tvalid never waits on tready, and data/last stay stable while tvalid is high and tready low.

`ifdef RXDMX_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    localparam logic [15:0] MAX_W  = 16'(MAX_WORDS);
    localparam logic [1:0]  DST_PT = 2'd0;
    localparam logic [1:0]  DST_S1 = 2'd1;
    localparam logic [1:0]  DST_S2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;
    logic        out_vld_q,  out_vld_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [1:0]  out_dst_q,  out_dst_d;
    logic        oversize_q, oversize_d;

    logic       sel_ready;
    logic       out_hs;
    logic       in_ready;
    logic       in_hs;
    logic       load;
    logic       ld_last;
    logic [1:0] ld_dst;
    logic [7:0] hdr_id;
    logic       hdr_drop;

    always_comb begin
        case (out_dst_q)
            DST_S1:  sel_ready = slt1_fifo.tready;
            DST_S2:  sel_ready = slt2_fifo.tready;
            default: sel_ready = passThru_fifo.tready;
        endcase
    end

    assign out_hs   = out_vld_q && sel_ready;
    assign in_ready = (state_q == ST_DROP) || !out_vld_q || sel_ready;
    assign in_hs    = rxif_fifo.tvalid && in_ready;
    assign hdr_id   = rxif_fifo.tdata[31:24];
    assign hdr_drop = DROP_EN && (hdr_id == DROP_ID);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        ld_last    = rxif_fifo.tlast;
        // out_dst_q only changes on a load, so inside a packet it still holds the locked destination.
        ld_dst     = out_dst_q;
        oversize_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    if (hdr_drop) begin
                        if (!rxif_fifo.tlast) state_d = ST_DROP;
                    end else begin
                        load  = 1'b1;
                        cnt_d = 16'd1;
                        if (hdr_id == SLT1_ID)      ld_dst = DST_S1;
                        else if (hdr_id == SLT2_ID) ld_dst = DST_S2;
                        else                        ld_dst = DST_PT;
                        if (!rxif_fifo.tlast) state_d = ST_PKT;
                    end
                end
            end
            ST_PKT: begin
                if (in_hs) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (rxif_fifo.tlast) begin
                        state_d = ST_IDLE;
                    end else if (cnt_d == MAX_W) begin
                        // Truncate: close the packet downstream and swallow the rest of it.
                        ld_last    = 1'b1;
                        oversize_d = 1'b1;
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (in_hs && rxif_fifo.tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_vld_d  = load || (out_vld_q && !out_hs);
        out_data_d = load ? rxif_fifo.tdata : out_data_q;
        out_last_d = load ? ld_last         : out_last_q;
        out_dst_d  = load ? ld_dst          : out_dst_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= 32'd0;
            out_last_q <= 1'b0;
            out_dst_q  <= DST_PT;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_dst_q  <= out_dst_d;
            oversize_q <= oversize_d;
        end
    end

    // Ready is forced low combinationally so it drops the instant rst rises.
    assign rxif_fifo.tready = !rst && in_ready;

    assign slt1_fifo.tvalid     = out_vld_q && (out_dst_q == DST_S1);
    assign slt1_fifo.tdata      = out_data_q;
    assign slt1_fifo.tlast      = out_last_q;
    assign slt2_fifo.tvalid     = out_vld_q && (out_dst_q == DST_S2);
    assign slt2_fifo.tdata      = out_data_q;
    assign slt2_fifo.tlast      = out_last_q;
    assign passThru_fifo.tvalid = out_vld_q && (out_dst_q == DST_PT);
    assign passThru_fifo.tdata  = out_data_q;
    assign passThru_fifo.tlast  = out_last_q;

    assign oversize  = oversize_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rx_demux.sv
// Self-checking bench for rx_demux: directed scenarios followed by randomized packets, checked against
// a packet-level reference model (per-destination expected queues). Honours RXDMX_DROP_EN when defined.
module tb_rx_demux;

    localparam int MAX_W = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       oversize;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    rx_demux_if rx ();
    rx_demux_if s1 ();
    rx_demux_if s2 ();
    rx_demux_if pt ();

    rx_demux #(.MAX_WORDS(MAX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxif_fifo     (rx),
        .slt1_fifo     (s1),
        .slt2_fifo     (s2),
        .passThru_fifo (pt),
        .oversize      (oversize),
        .dbg_state     (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // Expected words per destination: {tlast, tdata}; index 0 = passThru, 1 = slt1, 2 = slt2.
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    logic [31:0] pkt[$];
    int          exp_ov  = 0;
    int          ov_seen = 0;

    bit          rnd     = 1'b0;
    bit          cur_fwd = 1'b0;
    int          cur_dst = 0;
    bit          lat_v   = 1'b0;
    int          lat_dst = 0;
    logic [31:0] lat_word;
    bit          hold_v  = 1'b0;
    int          hold_dst = 0;
    logic [31:0] hold_word;
    logic        hold_last;

    logic        snap_rdy;
    logic        sv [3];
    logic        sr [3];
    logic        sl [3];
    logic [31:0] sd [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_dst(input logic [7:0] id);
`ifdef RXDMX_DROP_EN
        if (id == 8'hFF) return 3;
`endif
        if (id == 8'h01) return 1;
        if (id == 8'h02) return 2;
        return 0;
    endfunction

    task automatic push(input int d, input logic [32:0] w);
        case (d)
            1:       exp_q1.push_back(w);
            2:       exp_q2.push_back(w);
            default: exp_q0.push_back(w);
        endcase
    endtask

    function automatic int q_total();
        return exp_q0.size() + exp_q1.size() + exp_q2.size();
    endfunction

    // Expected output of the packet in pkt: first MAX_W words at most, last one closing the packet.
    task automatic model_pkt(output int dst);
        logic [31:0] hdr;
        int n;
        hdr = pkt[0];
        n   = pkt.size();
        dst = model_dst(hdr[31:24]);
        if (dst != 3) begin
            for (int k = 0; k < n && k < MAX_W; k++)
                push(dst, {((k == n - 1) || (k == MAX_W - 1)), pkt[k]});
            if (n > MAX_W) exp_ov++;
        end
    endtask

    task automatic mk_pkt(input logic [31:0] hdr, input int n);
        pkt.delete();
        pkt.push_back(hdr);
        for (int k = 1; k < n; k++) pkt.push_back($urandom);
    endtask

    task automatic chk_sink(input int d);
        logic [32:0] e;
        int qs;
        if (sv[d] && sr[d]) begin
            qs = (d == 1) ? exp_q1.size() : (d == 2) ? exp_q2.size() : exp_q0.size();
            check($sformatf("sb_pending_dst%0d", d), 32'(qs != 0), 32'd1);
            if (qs != 0) begin
                case (d)
                    1:       e = exp_q1.pop_front();
                    2:       e = exp_q2.pop_front();
                    default: e = exp_q0.pop_front();
                endcase
                check($sformatf("sb_data_dst%0d", d), sd[d], e[31:0]);
                check($sformatf("sb_last_dst%0d", d), 32'(sl[d]), 32'(e[32]));
            end
        end
    endtask

    // One clock: sample and check at negedge, return whether the input word is taken at the next posedge.
    task automatic tick(output bit acc);
        @(negedge clk);
        snap_rdy = rx.tready;
        sv[0] = pt.tvalid; sr[0] = pt.tready; sl[0] = pt.tlast; sd[0] = pt.tdata;
        sv[1] = s1.tvalid; sr[1] = s1.tready; sl[1] = s1.tlast; sd[1] = s1.tdata;
        sv[2] = s2.tvalid; sr[2] = s2.tready; sl[2] = s2.tlast; sd[2] = s2.tdata;
        if (lat_v) begin
            check("latency_onehot", 32'({sv[2], sv[1], sv[0]}), 32'(3'b001 << lat_dst));
            check("latency_data", sd[lat_dst], lat_word);
        end
        if (hold_v) begin
            check("hold_valid", 32'(sv[hold_dst]), 32'd1);
            check("hold_data", sd[hold_dst], hold_word);
            check("hold_last", 32'(sl[hold_dst]), 32'(hold_last));
        end
        hold_v = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (sv[d] && !sr[d]) begin
                hold_v = 1'b1; hold_dst = d; hold_word = sd[d]; hold_last = sl[d];
            end
        end
        for (int d = 0; d < 3; d++) chk_sink(d);
        if (oversize) ov_seen++;
        acc      = rx.tvalid && rx.tready;
        lat_v    = acc && cur_fwd;
        lat_dst  = cur_dst;
        lat_word = rx.tdata;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt();
        int n, dst, i, cyc;
        bit acc;
        n = pkt.size();
        model_pkt(dst);
        i = 0;
        cyc = 0;
        while (i < n) begin
            if (rnd) begin
                rx.tvalid  = ($urandom_range(0, 3) != 0);
                s1.tready  = ($urandom_range(0, 3) != 0);
                s2.tready  = ($urandom_range(0, 3) != 0);
                pt.tready  = ($urandom_range(0, 3) != 0);
            end else begin
                rx.tvalid = 1'b1;
                s1.tready = 1'b1; s2.tready = 1'b1; pt.tready = 1'b1;
            end
            rx.tdata = pkt[i];
            rx.tlast = (i == n - 1);
            cur_fwd  = (dst != 3) && (i < MAX_W);
            cur_dst  = (dst == 3) ? 0 : dst;
            tick(acc);
            if (!rnd) check("no_stall", 32'(snap_rdy), 32'd1);
            if (acc) i++;
            cyc++;
            if (cyc > 400) begin
                check("input_timeout", 32'(i), 32'(n));
                break;
            end
        end
        rx.tvalid = 1'b0;
        cur_fwd   = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        rx.tvalid = 1'b0;
        cur_fwd   = 1'b0;
        s1.tready = 1'b1; s2.tready = 1'b1; pt.tready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (q_total() == 0) break;
            tick(acc);
        end
        check("drain_empty", 32'(q_total()), 32'd0);
        tick(acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int ov0;
        int bi;
        logic [31:0] ids [4];

        rst = 1'b1;
        rx.tvalid = 1'b0; rx.tdata = 32'd0; rx.tlast = 1'b0;
        s1.tready = 1'b1; s2.tready = 1'b1; pt.tready = 1'b1;
        #2;
        check("rst_in_ready", 32'(rx.tready), 32'd0);
        check("rst_s1_valid", 32'(s1.tvalid), 32'd0);
        check("rst_s2_valid", 32'(s2.tvalid), 32'd0);
        check("rst_pt_valid", 32'(pt.tvalid), 32'd0);
        check("rst_s1_data", s1.tdata, 32'd0);
        check("rst_pt_last", 32'(pt.tlast), 32'd0);
        check("rst_oversize", 32'(oversize), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(rx.tready), 32'd1);

        // Basic routing, packets back to back with all sinks ready.
        pkt.delete(); pkt.push_back(32'h01AABBCC); pkt.push_back(32'h11111111); pkt.push_back(32'h22222222);
        send_pkt();
        pkt.delete(); pkt.push_back(32'h02000000); pkt.push_back(32'h33333333);
        send_pkt();
        pkt.delete(); pkt.push_back(32'h55000000); pkt.push_back(32'h44444444);
        pkt.push_back(32'h55555555); pkt.push_back(32'h66666666);
        send_pkt();
        drain();

        // Backpressure on slt2 for packet cycles 2-4; this 5-word packet is also exactly full.
        ov0 = ov_seen;
        mk_pkt(32'h02000005, 5);
        model_pkt(bi);
        bi = 0;
        for (int k = 1; k <= 20 && bi < 5; k++) begin
            rx.tvalid = 1'b1;
            rx.tdata  = pkt[bi];
            rx.tlast  = (bi == 4);
            s1.tready = 1'b1; pt.tready = 1'b1;
            s2.tready = !(k >= 2 && k <= 4);
            cur_fwd   = 1'b1;
            cur_dst   = 2;
            tick(acc);
            check("bp_in_ready", 32'(snap_rdy), 32'(!(k >= 2 && k <= 4)));
            if (k >= 2 && k <= 4) check("bp_hold_word1", sd[2], pkt[0]);
            if (acc) bi++;
        end
        check("bp_words_sent", 32'(bi), 32'd5);
        drain();
        check("exact_full_no_oversize", 32'(ov_seen - ov0), 32'd0);

        // Three single-word packets on consecutive cycles.
        pkt.delete(); pkt.push_back(32'h01000011); send_pkt();
        pkt.delete(); pkt.push_back(32'h02000022); send_pkt();
        pkt.delete(); pkt.push_back(32'h01000033); send_pkt();
        drain();

        // Truncation: 7 words to slt1, then a packet to slt2 must route normally.
        ov0 = ov_seen;
        mk_pkt(32'h01000007, 7); send_pkt();
        mk_pkt(32'h02000002, 2); send_pkt();
        drain();
        check("trunc_oversize_once", 32'(ov_seen - ov0), 32'd1);

        // Drop-ID packet followed by a slt1 packet.
        mk_pkt(32'hFF000000, 3); send_pkt();
        mk_pkt(32'h01000003, 3); send_pkt();
        drain();

        // Reset during word 2 of a 4-word packet.
        rx.tvalid = 1'b1; rx.tdata = 32'h01000100; rx.tlast = 1'b0;
        push(1, {1'b0, 32'h01000100});
        cur_fwd = 1'b1; cur_dst = 1;
        tick(acc);
        rx.tdata = 32'h01000101;
        tick(acc);
        rst = 1'b1;
        rx.tvalid = 1'b0; cur_fwd = 1'b0; lat_v = 1'b0; hold_v = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(rx.tready), 32'd0);
        check("mid_rst_valids", 32'({s2.tvalid, s1.tvalid, pt.tvalid}), 32'd0);
        check("mid_rst_data", s1.tdata, 32'd0);
        check("mid_rst_last", 32'(s1.tlast), 32'd0);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        mk_pkt(32'h02000200, 2); send_pkt();
        drain();

        // Randomized traffic with random valid gaps and sink backpressure.
        ids[0] = 32'h01; ids[1] = 32'h02; ids[2] = 32'hFF; ids[3] = 32'h00;
        rnd = 1'b1;
        for (int p = 0; p < 60; p++) begin
            logic [31:0] h;
            h = ids[$urandom_range(0, 3)];
            if (h == 32'h00) h = 32'($urandom_range(0, 255));
            mk_pkt({h[7:0], 24'($urandom)}, $urandom_range(1, 8));
            send_pkt();
        end
        rnd = 1'b0;
        drain();

        check("final_queues_empty", 32'(q_total()), 32'd0);
        check("final_oversize_count", 32'(ov_seen), 32'(exp_ov));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
